// File: rtl/stream_arbiter.sv
// rtl/stream_arbiter.sv - round-robin NUM_REQ:1 valid/ready arbiter with a registered depth-2 output stage
// Optional packet lock: define STREAM_ARB_LOCK_EN.
module stream_arbiter #(
  parameter int  NUM_REQ    = 2,
  parameter int  DATA_WIDTH = 1,
  parameter type TYPE       = logic [DATA_WIDTH-1:0],
  localparam int SEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] w_valid,
  output logic [NUM_REQ-1:0] w_ready,
  input  TYPE                w_data [NUM_REQ],
  input  logic [NUM_REQ-1:0] w_last,
  output logic               r_valid,
  input  logic               r_ready,
  output TYPE                r_data,
  output logic               r_last,
  output logic [SEL_W-1:0]   r_sel
);

  logic             skid_valid;
  logic             skid_next;
  TYPE              skid_data;
  logic             skid_last;
  logic [SEL_W-1:0] skid_sel;
  logic             accept;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W-1:0] lo_idx;
  logic [SEL_W-1:0] hi_idx;
  logic             lo_any;
  logic             hi_any;
  logic [SEL_W-1:0] grant;
  logic             grant_any;
  logic             hs;
  logic             load_buf;
  TYPE              in_data;
  logic             in_last;

`ifdef STREAM_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  lock_state_t      lock_state;
  logic [SEL_W-1:0] lock_src;
`endif

  // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    lo_any = 1'b0;
    hi_any = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_valid[j]) begin
        lo_idx = SEL_W'(j);
        lo_any = 1'b1;
        if (SEL_W'(j) >= ptr) begin
          hi_idx = SEL_W'(j);
          hi_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant     = hi_any ? hi_idx : lo_idx;
    grant_any = lo_any;
`ifdef STREAM_ARB_LOCK_EN
    if (lock_state == LOCKED) begin
      grant     = lock_src;
      grant_any = w_valid[lock_src];
    end
`endif
  end

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      w_ready[j] = accept && grant_any && (grant == SEL_W'(j));
    end
  end

  assign hs        = accept && grant_any;
  assign in_data   = w_data[grant];
  assign in_last   = w_last[grant];
  assign next_ptr  = (grant == SEL_W'(NUM_REQ - 1)) ? '0 : grant + SEL_W'(1);
  assign load_buf  = !r_valid || r_ready;
  assign skid_next = load_buf ? 1'b0 : (skid_valid || hs);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid    <= 1'b0;
      skid_valid <= 1'b0;
      accept     <= 1'b0;
      ptr        <= '0;
`ifdef STREAM_ARB_LOCK_EN
      lock_state <= IDLE;
      lock_src   <= '0;
`endif
    end else begin
      if (load_buf) begin
        r_valid <= skid_valid || hs;
      end
      skid_valid <= skid_next;
      accept     <= !skid_next;
      if (hs) begin
`ifdef STREAM_ARB_LOCK_EN
        if (in_last) begin
          ptr <= next_ptr;
        end
        case (lock_state)
          IDLE: begin
            if (!in_last) begin
              lock_state <= LOCKED;
              lock_src   <= grant;
            end
          end
          LOCKED: begin
            if (in_last) begin
              lock_state <= IDLE;
            end
          end
          default: lock_state <= IDLE;
        endcase
`else
        ptr <= next_ptr;
`endif
      end
    end
  end

  // Payload registers carry no reset; they are qualified by r_valid / skid_valid.
  always_ff @(posedge clk) begin
    if (load_buf) begin
      if (skid_valid) begin
        r_data <= skid_data;
        r_last <= skid_last;
        r_sel  <= skid_sel;
      end else if (hs) begin
        r_data <= in_data;
        r_last <= in_last;
        r_sel  <= grant;
      end
    end else if (hs) begin
      skid_data <= in_data;
      skid_last <= in_last;
      skid_sel  <= grant;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src_chk
    a_src_stable: assert property (@(posedge clk) disable iff (!rstn)
      (w_valid[i] && !w_ready[i]) |=> (w_valid[i] && $stable(w_data[i])));
  end

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(w_ready));

endmodule
